sr_load_sched: RTL and testbench

//  Schedules and serialises loads of the chip's dynamic (16 b) and static (88 b) shift registers.
//  Two requesters post parallel words with a REQ/ACK handshake.

---
 rtl/sr_load_sched.sv | 175 +++++++++++++++++
 tb/tb_sr_load_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_load_sched.sv
// Round-robin scheduler that serialises dynamic/static register words onto the chip's SEL/MOSI/CLK pins.
// Optional readback of the chip's shift-out (SR_MISO) is built when SR_READBACK_EN is defined.
module sr_load_sched #(
  parameter int DYN_LEN    = 16,
  parameter int STAT_LEN   = 88,
  parameter int GAP_CYCLES = 30
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                DYN_REQ,
  input  logic [DYN_LEN-1:0]  DYN_DATA,
  output logic                DYN_ACK,
  input  logic                STAT_REQ,
  input  logic [STAT_LEN-1:0] STAT_DATA,
  output logic                STAT_ACK,
  output logic                BUSY,
  output logic                DONE,
  output logic                DONE_ID,
  output logic                SR_SEL,
  output logic                SR_MOSI,
  output logic                SR_CLK
`ifdef SR_READBACK_EN
  ,
  input  logic                SR_MISO,
  output logic [STAT_LEN-1:0] RB_DATA,
  output logic                RB_VALID
`endif
);

  localparam int BW = $clog2(STAT_LEN) + 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_END   = GW'(GAP_CYCLES);
  localparam logic [BW-1:0] DYN_LAST  = BW'(DYN_LEN - 1);
  localparam logic [BW-1:0] STAT_LAST = BW'(STAT_LEN - 1);

  if (DYN_LEN > STAT_LEN) begin : g_len_chk
    $error("sr_load_sched: DYN_LEN must not exceed STAT_LEN");
  end

  typedef enum logic [1:0] {S_GAP, S_IDLE, S_SHIFT, S_TAIL} state_t;

  state_t              state, state_n;
  logic [GW-1:0]       gap_cnt, gap_cnt_n;
  logic [BW-1:0]       bit_cnt, bit_cnt_n;
  logic                phase, phase_n;
  logic                tgt, tgt_n;
  logic                last_stat, last_stat_n;
  logic [STAT_LEN-1:0] shreg, shreg_n;
  logic                sel_n, mosi_n, sclk_n, dyn_ack_n, stat_ack_n;
  logic                done_n, done_id_n, busy_n, grant_stat;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_GAP;
      gap_cnt   <= '0;
      bit_cnt   <= '0;
      phase     <= 1'b0;
      tgt       <= 1'b1;
      last_stat <= 1'b1;
      shreg     <= '0;
      SR_SEL    <= 1'b1;
      SR_MOSI   <= 1'b0;
      SR_CLK    <= 1'b0;
      DYN_ACK   <= 1'b0;
      STAT_ACK  <= 1'b0;
      DONE      <= 1'b0;
      DONE_ID   <= 1'b0;
      BUSY      <= 1'b1;
    end else begin
      state     <= state_n;
      gap_cnt   <= gap_cnt_n;
      bit_cnt   <= bit_cnt_n;
      phase     <= phase_n;
      tgt       <= tgt_n;
      last_stat <= last_stat_n;
      shreg     <= shreg_n;
      SR_SEL    <= sel_n;
      SR_MOSI   <= mosi_n;
      SR_CLK    <= sclk_n;
      DYN_ACK   <= dyn_ack_n;
      STAT_ACK  <= stat_ack_n;
      DONE      <= done_n;
      DONE_ID   <= done_id_n;
      BUSY      <= busy_n;
    end
  end

  always_comb begin
    state_n     = state;
    gap_cnt_n   = gap_cnt;
    bit_cnt_n   = bit_cnt;
    phase_n     = phase;
    tgt_n       = tgt;
    last_stat_n = last_stat;
    shreg_n     = shreg;
    sel_n       = SR_SEL;
    mosi_n      = SR_MOSI;
    sclk_n      = 1'b0;
    dyn_ack_n   = 1'b0;
    stat_ack_n  = 1'b0;
    done_n      = 1'b0;
    done_id_n   = DONE_ID;
    grant_stat  = 1'b0;
    case (state)
      S_GAP: begin
        sel_n  = 1'b1;
        mosi_n = 1'b0;
        if (gap_cnt == GAP_END) state_n = S_IDLE;
        else                    gap_cnt_n = gap_cnt + 1'b1;
      end
      S_IDLE: begin
        if (DYN_REQ || STAT_REQ) begin
          // On contention the side not served last wins.
          grant_stat = STAT_REQ && (!DYN_REQ || !last_stat);
          if (grant_stat) shreg_n = STAT_DATA;
          else begin
            shreg_n = '0;
            shreg_n[STAT_LEN-1 -: DYN_LEN] = DYN_DATA;
          end
          mosi_n      = shreg_n[STAT_LEN-1];
          tgt_n       = grant_stat;
          last_stat_n = grant_stat;
          sel_n       = grant_stat;
          dyn_ack_n   = !grant_stat;
          stat_ack_n  = grant_stat;
          bit_cnt_n   = '0;
          phase_n     = 1'b0;
          state_n     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!phase) begin
          sclk_n  = 1'b1;
          phase_n = 1'b1;
        end else if (bit_cnt == (tgt ? STAT_LAST : DYN_LAST)) begin
          state_n   = S_TAIL;
          mosi_n    = 1'b0;
          done_n    = 1'b1;
          done_id_n = tgt;
        end else begin
          // Rotate rather than shift so every shifter bit is consumed; leftovers are don't-care.
          shreg_n   = {shreg[STAT_LEN-2:0], shreg[STAT_LEN-1]};
          mosi_n    = shreg[STAT_LEN-2];
          bit_cnt_n = bit_cnt + 1'b1;
          phase_n   = 1'b0;
        end
      end
      S_TAIL: begin
        sel_n  = 1'b1;
        mosi_n = 1'b0;
        if (GAP_CYCLES == 0) state_n = S_IDLE;
        else begin
          state_n   = S_GAP;
          gap_cnt_n = GW'(1);
        end
      end
      default: state_n = S_GAP;
    endcase
    busy_n = (state_n != S_IDLE);
  end

`ifdef SR_READBACK_EN
  // Capture on the edge that raises SR_CLK, before the chip shifts its next bit out.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RB_DATA  <= '0;
      RB_VALID <= 1'b0;
    end else begin
      RB_VALID <= done_n;
      if (state == S_SHIFT && !phase) RB_DATA <= {RB_DATA[STAT_LEN-2:0], SR_MISO};
    end
  end
`endif

endmodule

// File: tb/tb_sr_load_sched.sv
// Scoreboard bench for sr_load_sched: driver pushes model-predicted frames, negedge monitor decodes pins and checks.
module tb_sr_load_sched;
  localparam int DL = 16, SL = 88, GAP = 30;

  logic CLK = 1'b0, RST_N = 1'b0;
  logic dyn_req, stat_req;
  logic [DL-1:0] dyn_data;
  logic [SL-1:0] stat_data;
  logic dyn_ack, stat_ack, busy, done, done_id, sr_sel, sr_mosi, sr_clk;

  logic g0_rst = 1'b0, g0_req = 1'b0;
  logic [DL-1:0] g0_data = 16'h5A3C;
  logic g0_ack, g0_sack, g0_busy, g0_done, g0_done_id, g0_sel, g0_mosi, g0_clk;
  bit   g0_fin = 0;

  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc++;

`ifdef SR_READBACK_EN
  logic sr_miso, g0_miso = 1'b0, rb_valid, g0_rb_valid;
  logic [SL-1:0] rb_data, g0_rb_data;
  logic [DL-1:0] dyn_chip = 16'h1234, dyn_snap;
  logic [SL-1:0] stat_chip = 88'h0F0E0D0C0B0A0908070605, stat_snap;
  always @(posedge sr_clk)
    if (!sr_sel) dyn_chip <= {dyn_chip[DL-2:0], sr_mosi};
    else         stat_chip <= {stat_chip[SL-2:0], sr_mosi};
  assign sr_miso = sr_sel ? stat_chip[SL-1] : dyn_chip[DL-1];
`endif

  sr_load_sched #(.DYN_LEN(DL), .STAT_LEN(SL), .GAP_CYCLES(GAP)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .DYN_REQ(dyn_req), .DYN_DATA(dyn_data), .DYN_ACK(dyn_ack),
    .STAT_REQ(stat_req), .STAT_DATA(stat_data), .STAT_ACK(stat_ack),
    .BUSY(busy), .DONE(done), .DONE_ID(done_id),
    .SR_SEL(sr_sel), .SR_MOSI(sr_mosi), .SR_CLK(sr_clk)
`ifdef SR_READBACK_EN
    , .SR_MISO(sr_miso), .RB_DATA(rb_data), .RB_VALID(rb_valid)
`endif
  );

  sr_load_sched #(.DYN_LEN(DL), .STAT_LEN(SL), .GAP_CYCLES(0)) dut_g0 (
    .CLK(CLK), .RST_N(g0_rst),
    .DYN_REQ(g0_req), .DYN_DATA(g0_data), .DYN_ACK(g0_ack),
    .STAT_REQ(1'b0), .STAT_DATA({SL{1'b0}}), .STAT_ACK(g0_sack),
    .BUSY(g0_busy), .DONE(g0_done), .DONE_ID(g0_done_id),
    .SR_SEL(g0_sel), .SR_MOSI(g0_mosi), .SR_CLK(g0_clk)
`ifdef SR_READBACK_EN
    , .SR_MISO(g0_miso), .RB_DATA(g0_rb_data), .RB_VALID(g0_rb_valid)
`endif
  );

  int n_chk = 0, n_pass = 0;

  task automatic check_i(input string name, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic check_w(input string name, input logic [SL-1:0] got, input logic [SL-1:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic fail_timeout(input string name);
    n_chk++;
    $display("FAIL %s: timed out, got no event want event (cycle %0d)", name, cyc);
  endtask

  // Expected frame: target, word right-aligned, length, and whether the ACK must follow the previous DONE by GAP+2.
  typedef struct {
    bit            id;
    logic [SL-1:0] data;
    int            len;
    bit            gap_chk;
  } frame_t;
  frame_t sb[$];
  bit m_last_stat = 1;

  // Monitor
  int ack_cyc = 0, last_done = -1000, nbits = 0;
  bit cur_sel = 0, sel_bad = 0, prev_sclk = 0;
  logic [SL-1:0] shv;
  frame_t mf;

  always @(negedge CLK) begin
    if (!RST_N) begin
      nbits = 0;
      prev_sclk = 0;
    end else begin
      if (dyn_ack || stat_ack) begin
        if (sb.size() == 0) check_i("ack_unexpected", int'({dyn_ack, stat_ack}), 0);
        else begin
          check_i("ack_id", int'({dyn_ack, stat_ack}), sb[0].id ? 1 : 2);
          check_i("ack_busy", int'(busy), 1);
          if (sb[0].gap_chk) check_i("ack_after_done", cyc - last_done, GAP + 2);
        end
        ack_cyc = cyc; nbits = 0; shv = '0; sel_bad = 0; cur_sel = stat_ack;
`ifdef SR_READBACK_EN
        dyn_snap = dyn_chip; stat_snap = stat_chip;
`endif
      end
      if (sr_clk && !prev_sclk) begin
        shv = {shv[SL-2:0], sr_mosi};
        nbits++;
        if (sr_sel !== cur_sel) sel_bad = 1;
      end
      prev_sclk = sr_clk;
      if (done) begin
        if (sb.size() == 0) check_i("done_unexpected", int'(done), 0);
        else begin
          mf = sb.pop_front();
          check_i("done_id", int'(done_id), int'(mf.id));
          check_i("frame_bits", nbits, mf.len);
          check_w("frame_data", shv, mf.data);
          check_i("frame_sel", int'(sel_bad), 0);
          check_i("frame_latency", cyc - ack_cyc, 2 * mf.len);
`ifdef SR_READBACK_EN
          check_i("rb_valid", int'(rb_valid), 1);
          if (!mf.id) check_i("rb_dyn", int'(rb_data[DL-1:0]), int'(dyn_snap));
          else        check_w("rb_stat", rb_data, stat_snap);
`endif
        end
        last_done = cyc;
      end
    end
  end

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin @(negedge CLK); t++; end
    if (sb.size() != 0) begin fail_timeout("frame_drain"); sb.delete(); end
  endtask

  task automatic trial(input bit d, input bit s, input logic [DL-1:0] dd,
                       input logic [SL-1:0] sd, output int first_ack);
    frame_t fd, fs;
    int t = 0;
    fd = '{1'b0, SL'(dd), DL, 1'b0};
    fs = '{1'b1, sd, SL, 1'b0};
    if (d && s) begin
      if (m_last_stat) begin sb.push_back(fd); fs.gap_chk = 1; sb.push_back(fs); m_last_stat = 1; end
      else             begin sb.push_back(fs); fd.gap_chk = 1; sb.push_back(fd); m_last_stat = 0; end
    end else if (d) begin sb.push_back(fd); m_last_stat = 0; end
    else            begin sb.push_back(fs); m_last_stat = 1; end
    dyn_data = dd; stat_data = sd; dyn_req = d; stat_req = s;
    first_ack = -1;
    while ((dyn_req || stat_req) && t < 3000) begin
      @(negedge CLK); t++;
      if (dyn_ack)  begin dyn_req = 0;  if (first_ack < 0) first_ack = cyc; end
      if (stat_ack) begin stat_req = 0; if (first_ack < 0) first_ack = cyc; end
    end
    if (dyn_req || stat_req) begin fail_timeout("ack_wait"); dyn_req = 0; stat_req = 0; end
    wait_drain();
  endtask

  // Zero-gap instance: held request gives back-to-back frames.
  initial begin : gap0
    int last_d, a, frames, t;
    last_d = -1; a = 0; frames = 0; t = 0;
    repeat (2) @(negedge CLK);
    g0_rst = 1; g0_req = 1;
    while (frames < 3 && t < 2000) begin
      @(negedge CLK); t++;
      if (g0_ack) begin
        if (last_d >= 0) check_i("g0_ack_after_done", cyc - last_d, 2);
        a = cyc;
      end
      if (g0_done) begin
        check_i("g0_frame_len", cyc - a, 2 * DL);
        last_d = cyc; frames++;
      end
    end
    if (frames < 3) fail_timeout("g0_frames");
    g0_req = 0; g0_fin = 1;
  end

  initial begin
    int rel, fa, ack_seen, t, mode;
    logic [SL-1:0] sd;
    dyn_req = 0; stat_req = 0; dyn_data = '0; stat_data = '0;
    repeat (3) @(negedge CLK);
    check_i("rst_sel", int'(sr_sel), 1);
    check_i("rst_mosi", int'(sr_mosi), 0);
    check_i("rst_sclk", int'(sr_clk), 0);
    check_i("rst_acks", int'({dyn_ack, stat_ack}), 0);
    check_i("rst_done", int'({done, done_id}), 0);
    check_i("rst_busy", int'(busy), 1);

    // Both requests right after reset: dynamic first, static GAP+2 after its DONE.
    RST_N = 1; rel = cyc;
    trial(1, 1, 16'hABCD, 88'h123456789ABCDEF1234567, fa);
    check_i("reset_to_ack", fa - rel, GAP + 2);

    // Request withdrawn just before IDLE is reached.
    dyn_data = 16'hFFFF; dyn_req = 1; t = 0;
    while (cyc < last_done + GAP && t < 200) begin @(negedge CLK); t++; end
    dyn_req = 0; ack_seen = 0;
    repeat (8) begin @(negedge CLK); if (dyn_ack || stat_ack) ack_seen++; end
    check_i("drop_no_ack", ack_seen, 0);
    check_i("drop_busy", int'(busy), 0);

    // After a dynamic frame, contention goes to static.
    trial(1, 0, 16'h0F0F, '0, fa);
    trial(1, 1, 16'h8001, 88'hFEDCBA98765432100C0FFE, fa);

    for (int i = 0; i < 12; i++) begin
      mode = $urandom_range(1, 3);
      sd = SL'({$urandom(), $urandom(), $urandom()});
      trial(mode[0], mode[1], DL'($urandom()), sd, fa);
      repeat ($urandom_range(0, 40)) @(negedge CLK);
    end

    // Reset in the middle of a static frame; the held request restarts it.
    sd = SL'({$urandom(), $urandom(), $urandom()});
    sb.push_back('{1'b1, sd, SL, 1'b0});
    stat_data = sd; stat_req = 1; t = 0;
    while (!(nbits >= 40 && prev_sclk) && t < 3000) begin @(negedge CLK); t++; end
    if (t >= 3000) fail_timeout("bit40_wait");
    #2 RST_N = 0;
    #1;
    check_i("abort_sel", int'(sr_sel), 1);
    check_i("abort_mosi_sclk", int'({sr_mosi, sr_clk}), 0);
    check_i("abort_done", int'(done), 0);
    check_i("abort_busy", int'(busy), 1);
    m_last_stat = 1;
    @(negedge CLK);
    RST_N = 1; rel = cyc; t = 0;
    while (!stat_ack && t < 200) begin @(negedge CLK); t++; end
    if (!stat_ack) fail_timeout("restart_ack");
    else check_i("restart_to_ack", cyc - rel, GAP + 2);
    stat_req = 0;
    wait_drain();

    t = 0;
    while (!g0_fin && t < 3000) begin @(negedge CLK); t++; end
    if (!g0_fin) fail_timeout("g0_finish");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
